ex_issue_stage: RTL and testbench

- Decode/execute pipeline boundary that feeds the ALU.
- Captures decoded operations from decode: function code, source and destination register indices, operand values and immediate.
- Holds them in a two-entry skid buffer with valid/ready handshakes on both sides.
- Keeps held operands current by forwarding register-file writebacks, then presents operands a/b, func and destination index to the ALU.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/ex_operand_fwd.sv | 20 ++
 rtl/ex_issue_stage.sv | 162 ++++++++++++++++
 tb/tb_ex_issue_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared widths, ALU function codes, issue-entry record and skid-buffer states
// for the decode/execute boundary.
package mips_pkg;

  localparam int DATA_SIZE = 32;
  localparam int FUNC_SIZE = 11;
  localparam int IDX_SIZE  = 5;

  localparam logic [FUNC_SIZE-1:0] FN_ADD = 11'd0;
  localparam logic [FUNC_SIZE-1:0] FN_SUB = 11'd1;
  localparam logic [FUNC_SIZE-1:0] FN_AND = 11'd2;
  localparam logic [FUNC_SIZE-1:0] FN_OR  = 11'd3;
  localparam logic [FUNC_SIZE-1:0] FN_XOR = 11'd4;
  localparam logic [FUNC_SIZE-1:0] FN_SLT = 11'd5;

  typedef struct packed {
    logic [FUNC_SIZE-1:0] func;
    logic [IDX_SIZE-1:0]  rs_idx;
    logic [IDX_SIZE-1:0]  rt_idx;
    logic [IDX_SIZE-1:0]  rd_idx;
    logic [DATA_SIZE-1:0] a;
    logic [DATA_SIZE-1:0] b;
    logic                 b_is_reg;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FULL,
    ST_SKID
  } state_t;

endpackage

// File: rtl/ex_operand_fwd.sv
// Writeback bypass for one operand: replaces the value when the writeback
// targets the operand's source register (r0 and immediates never match).
module ex_operand_fwd
  import mips_pkg::*;
(
  input  logic [IDX_SIZE-1:0]  i_idx,
  input  logic [DATA_SIZE-1:0] i_val,
  input  logic                 i_en,
  input  logic                 i_wb_en,
  input  logic [IDX_SIZE-1:0]  i_wb_idx,
  input  logic [DATA_SIZE-1:0] i_wb_data,
  output logic [DATA_SIZE-1:0] o_val
);

  logic hit;

  assign hit   = i_en & i_wb_en & (i_wb_idx != '0) & (i_wb_idx == i_idx);
  assign o_val = hit ? i_wb_data : i_val;

endmodule

// File: rtl/ex_issue_stage.sv
// Two-entry skid buffer between decode and the ALU; held operands are kept
// current with register-file writebacks. Accepted ops appear one cycle later.
module ex_issue_stage
  import mips_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [FUNC_SIZE-1:0] i_func,
  input  logic [IDX_SIZE-1:0]  i_rs_idx,
  input  logic [IDX_SIZE-1:0]  i_rt_idx,
  input  logic [IDX_SIZE-1:0]  i_rd_idx,
  input  logic [DATA_SIZE-1:0] i_rs_val,
  input  logic [DATA_SIZE-1:0] i_rt_val,
  input  logic [DATA_SIZE-1:0] i_imm,
  input  logic                 i_use_imm,
  input  logic                 i_wb_en,
  input  logic [IDX_SIZE-1:0]  i_wb_idx,
  input  logic [DATA_SIZE-1:0] i_wb_data,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [FUNC_SIZE-1:0] o_func,
  output logic [DATA_SIZE-1:0] o_a,
  output logic [DATA_SIZE-1:0] o_b,
  output logic [IDX_SIZE-1:0]  o_rd_idx,
  output logic [31:0]          o_issue_cnt
);

  state_t      state, state_nx;
  entry_t      main_q, skid_q;
  entry_t      cap, main_fwd, skid_fwd;
  logic        ready_q;
  logic [31:0] issue_cnt;
  logic        accept, fire;
  logic        load_main_in, load_main_skid, load_skid;

  assign o_valid     = (state != ST_EMPTY);
  assign o_ready     = ready_q;
  assign accept      = i_valid & ready_q;
  assign fire        = o_valid & i_ready;
  assign o_func      = main_q.func;
  assign o_a         = main_q.a;
  assign o_b         = main_q.b;
  assign o_rd_idx    = main_q.rd_idx;
  assign o_issue_cnt = issue_cnt;

  // Incoming capture: b comes from the immediate or from rt.
  assign cap.func     = i_func;
  assign cap.rs_idx   = i_rs_idx;
  assign cap.rt_idx   = i_rt_idx;
  assign cap.rd_idx   = i_rd_idx;
  assign cap.b_is_reg = ~i_use_imm;

  ex_operand_fwd u_fwd_cap_a (
    .i_idx(i_rs_idx), .i_val(i_rs_val), .i_en(1'b1),
    .i_wb_en(i_wb_en), .i_wb_idx(i_wb_idx), .i_wb_data(i_wb_data), .o_val(cap.a)
  );
  ex_operand_fwd u_fwd_cap_b (
    .i_idx(i_rt_idx), .i_val(i_use_imm ? i_imm : i_rt_val), .i_en(~i_use_imm),
    .i_wb_en(i_wb_en), .i_wb_idx(i_wb_idx), .i_wb_data(i_wb_data), .o_val(cap.b)
  );

  assign main_fwd.func     = main_q.func;
  assign main_fwd.rs_idx   = main_q.rs_idx;
  assign main_fwd.rt_idx   = main_q.rt_idx;
  assign main_fwd.rd_idx   = main_q.rd_idx;
  assign main_fwd.b_is_reg = main_q.b_is_reg;

  ex_operand_fwd u_fwd_main_a (
    .i_idx(main_q.rs_idx), .i_val(main_q.a), .i_en(1'b1),
    .i_wb_en(i_wb_en), .i_wb_idx(i_wb_idx), .i_wb_data(i_wb_data), .o_val(main_fwd.a)
  );
  ex_operand_fwd u_fwd_main_b (
    .i_idx(main_q.rt_idx), .i_val(main_q.b), .i_en(main_q.b_is_reg),
    .i_wb_en(i_wb_en), .i_wb_idx(i_wb_idx), .i_wb_data(i_wb_data), .o_val(main_fwd.b)
  );

  // The skid copy is forwarded too, so a skid->main move carries fresh values.
  assign skid_fwd.func     = skid_q.func;
  assign skid_fwd.rs_idx   = skid_q.rs_idx;
  assign skid_fwd.rt_idx   = skid_q.rt_idx;
  assign skid_fwd.rd_idx   = skid_q.rd_idx;
  assign skid_fwd.b_is_reg = skid_q.b_is_reg;

  ex_operand_fwd u_fwd_skid_a (
    .i_idx(skid_q.rs_idx), .i_val(skid_q.a), .i_en(1'b1),
    .i_wb_en(i_wb_en), .i_wb_idx(i_wb_idx), .i_wb_data(i_wb_data), .o_val(skid_fwd.a)
  );
  ex_operand_fwd u_fwd_skid_b (
    .i_idx(skid_q.rt_idx), .i_val(skid_q.b), .i_en(skid_q.b_is_reg),
    .i_wb_en(i_wb_en), .i_wb_idx(i_wb_idx), .i_wb_data(i_wb_data), .o_val(skid_fwd.b)
  );

  always_comb begin
    state_nx       = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (i_flush) begin
      state_nx = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_nx     = ST_FULL;
            load_main_in = 1'b1;
          end
        end
        ST_FULL: begin
          if (accept && fire) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_nx  = ST_SKID;
            load_skid = 1'b1;
          end else if (fire) begin
            state_nx = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (fire) begin
            state_nx       = ST_FULL;
            load_main_skid = 1'b1;
          end
        end
        default: state_nx = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_EMPTY;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state   <= state_nx;
      ready_q <= (state_nx != ST_SKID);
      if (load_main_in)
        main_q <= cap;
      else if (load_main_skid)
        main_q <= skid_fwd;
      else
        main_q <= main_fwd;
      if (load_skid)
        skid_q <= cap;
      else
        skid_q <= skid_fwd;
    end
  end

  // A fire in a flush cycle still counts: the ALU already took the op.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      issue_cnt <= '0;
    else if (fire)
      issue_cnt <= issue_cnt + 32'd1;
  end

endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed bench for ex_issue_stage: hand-computed expectations for handshake,
// skid ordering, forwarding, flush, counter wrap and mid-operation reset.
module tb_ex_issue_stage;
  import mips_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 i_valid, o_ready;
  logic [FUNC_SIZE-1:0] i_func;
  logic [IDX_SIZE-1:0]  i_rs_idx, i_rt_idx, i_rd_idx;
  logic [DATA_SIZE-1:0] i_rs_val, i_rt_val, i_imm;
  logic                 i_use_imm;
  logic                 i_wb_en;
  logic [IDX_SIZE-1:0]  i_wb_idx;
  logic [DATA_SIZE-1:0] i_wb_data;
  logic                 i_flush;
  logic                 o_valid, i_ready;
  logic [FUNC_SIZE-1:0] o_func;
  logic [DATA_SIZE-1:0] o_a, o_b;
  logic [IDX_SIZE-1:0]  o_rd_idx;
  logic [31:0]          o_issue_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ex_issue_stage dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_func(i_func), .i_rs_idx(i_rs_idx), .i_rt_idx(i_rt_idx), .i_rd_idx(i_rd_idx),
    .i_rs_val(i_rs_val), .i_rt_val(i_rt_val), .i_imm(i_imm), .i_use_imm(i_use_imm),
    .i_wb_en(i_wb_en), .i_wb_idx(i_wb_idx), .i_wb_data(i_wb_data),
    .i_flush(i_flush),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_func(o_func), .o_a(o_a), .o_b(o_b), .o_rd_idx(o_rd_idx),
    .o_issue_cnt(o_issue_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input int func, input int rs, input int rt, input int rd,
                          input logic [31:0] rsv, input logic [31:0] rtv,
                          input logic [31:0] imm, input logic use_imm);
    i_valid   = 1'b1;
    i_func    = FUNC_SIZE'(func);
    i_rs_idx  = IDX_SIZE'(rs);
    i_rt_idx  = IDX_SIZE'(rt);
    i_rd_idx  = IDX_SIZE'(rd);
    i_rs_val  = rsv;
    i_rt_val  = rtv;
    i_imm     = imm;
    i_use_imm = use_imm;
  endtask

  task automatic set_wb(input logic en, input int idx, input logic [31:0] data);
    i_wb_en   = en;
    i_wb_idx  = IDX_SIZE'(idx);
    i_wb_data = data;
  endtask

  initial begin
    rst_n = 1'b0;
    i_valid = 1'b0; i_func = '0; i_rs_idx = '0; i_rt_idx = '0; i_rd_idx = '0;
    i_rs_val = '0; i_rt_val = '0; i_imm = '0; i_use_imm = 1'b0;
    i_flush = 1'b0; i_ready = 1'b0;
    set_wb(1'b0, 0, 32'h0);
    #12;
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_a", o_a, 32'd0);
    check("rst_cnt", o_issue_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single op, full latency.
    i_ready = 1'b1;
    drive_op(0, 1, 2, 3, 32'd5, 32'd7, 32'd0, 1'b0);
    tick();
    i_valid = 1'b0;
    check("s_valid", {31'd0, o_valid}, 32'd1);
    check("s_a", o_a, 32'd5);
    check("s_b", o_b, 32'd7);
    check("s_func", {21'd0, o_func}, 32'd0);
    check("s_rd", {27'd0, o_rd_idx}, 32'd3);
    tick();
    check("s_cnt", o_issue_cnt, 32'd1);
    check("s_empty", {31'd0, o_valid}, 32'd0);

    // Backpressure: three ops, third held by decode.
    i_ready = 1'b0;
    drive_op(1, 1, 2, 10, 32'd100, 32'd0, 32'd0, 1'b0);
    tick();
    check("bp_rd1", {27'd0, o_rd_idx}, 32'd10);
    drive_op(2, 1, 2, 11, 32'd200, 32'd0, 32'd0, 1'b0);
    tick();
    check("bp_ready0", {31'd0, o_ready}, 32'd0);
    check("bp_a1", o_a, 32'd100);
    drive_op(3, 1, 2, 12, 32'd300, 32'd0, 32'd0, 1'b0);
    tick();
    check("bp_hold_rd", {27'd0, o_rd_idx}, 32'd10);
    i_ready = 1'b1;
    tick();
    check("bp_rd2", {27'd0, o_rd_idx}, 32'd11);
    check("bp_a2", o_a, 32'd200);
    check("bp_cnt2", o_issue_cnt, 32'd2);
    check("bp_ready1", {31'd0, o_ready}, 32'd1);
    tick();
    i_valid = 1'b0;
    check("bp_rd3", {27'd0, o_rd_idx}, 32'd12);
    check("bp_func3", {21'd0, o_func}, 32'd3);
    check("bp_cnt3", o_issue_cnt, 32'd3);
    tick();
    check("bp_cnt4", o_issue_cnt, 32'd4);
    check("bp_empty", {31'd0, o_valid}, 32'd0);

    // Forwarding onto a stalled main entry.
    i_ready = 1'b0;
    drive_op(2, 4, 6, 7, 32'd1, 32'd9, 32'd0, 1'b0);
    tick();
    i_valid = 1'b0;
    check("fw_a0", o_a, 32'd1);
    set_wb(1'b1, 4, 32'h55);
    tick();
    check("fw_a", o_a, 32'h55);
    set_wb(1'b1, 0, 32'h77);
    tick();
    check("fw_r0_a", o_a, 32'h55);
    set_wb(1'b1, 6, 32'h66);
    tick();
    check("fw_b", o_b, 32'h66);
    set_wb(1'b0, 0, 32'h0);
    i_ready = 1'b1;
    tick();
    check("fw_cnt", o_issue_cnt, 32'd5);

    // Immediate operand is never forwarded.
    i_ready = 1'b0;
    drive_op(0, 1, 8, 2, 32'd0, 32'd3, 32'hFFFFFFFC, 1'b1);
    tick();
    i_valid = 1'b0;
    set_wb(1'b1, 8, 32'h99);
    tick();
    check("imm_b", o_b, 32'hFFFFFFFC);
    set_wb(1'b0, 0, 32'h0);
    i_ready = 1'b1;
    tick();

    // Capture-path forward with rs==rt, then skid->main forward.
    i_ready = 1'b0;
    drive_op(0, 9, 9, 1, 32'd2, 32'd3, 32'd0, 1'b0);
    set_wb(1'b1, 9, 32'd8);
    tick();
    set_wb(1'b0, 0, 32'h0);
    check("cap_a", o_a, 32'd8);
    check("cap_b", o_b, 32'd8);
    drive_op(1, 12, 0, 2, 32'd1, 32'd0, 32'd0, 1'b0);
    tick();
    i_valid = 1'b0;
    set_wb(1'b1, 12, 32'hAB);
    i_ready = 1'b1;
    tick();
    check("skid_mv_a", o_a, 32'hAB);
    check("skid_cnt", o_issue_cnt, 32'd7);

    // Flush while in SKID with a same-cycle input.
    set_wb(1'b0, 0, 32'h0);
    i_ready = 1'b0;
    drive_op(4, 1, 2, 5, 32'd11, 32'd12, 32'd0, 1'b0);
    tick();
    check("fl_ready_pre", {31'd0, o_ready}, 32'd0);
    i_flush = 1'b1;
    drive_op(5, 1, 2, 6, 32'd13, 32'd14, 32'd0, 1'b0);
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    check("fl_valid", {31'd0, o_valid}, 32'd0);
    check("fl_ready", {31'd0, o_ready}, 32'd1);
    check("fl_cnt", o_issue_cnt, 32'd7);
    tick();
    check("fl_stay_empty", {31'd0, o_valid}, 32'd0);
    i_ready = 1'b1;
    drive_op(13, 1, 2, 31, 32'h1234, 32'd0, 32'd0, 1'b0);
    tick();
    i_valid = 1'b0;
    check("post_func", {21'd0, o_func}, 32'd13);
    check("post_a", o_a, 32'h1234);
    check("post_rd", {27'd0, o_rd_idx}, 32'd31);
    tick();
    check("post_cnt", o_issue_cnt, 32'd8);

    // Counter wrap.
    force dut.issue_cnt = 32'hFFFFFFFF;
    tick();
    release dut.issue_cnt;
    tick();
    check("wrap_pre", o_issue_cnt, 32'hFFFFFFFF);
    drive_op(0, 1, 2, 3, 32'd1, 32'd1, 32'd0, 1'b0);
    tick();
    i_valid = 1'b0;
    tick();
    check("wrap_cnt", o_issue_cnt, 32'd0);

    // Reset mid-operation.
    i_ready = 1'b0;
    drive_op(3, 1, 2, 9, 32'h42, 32'h43, 32'd0, 1'b0);
    tick();
    drive_op(3, 1, 2, 10, 32'h44, 32'h45, 32'd0, 1'b0);
    tick();
    i_valid = 1'b0;
    check("mid_valid_pre", {31'd0, o_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_valid", {31'd0, o_valid}, 32'd0);
    check("mid_ready", {31'd0, o_ready}, 32'd1);
    check("mid_a", o_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    i_ready = 1'b1;
    tick();
    check("mid_no_issue", {31'd0, o_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
